// File: rtl/load_store_unit_pkg.sv
// Shared widths, FSM encoding and store-buffer entry type for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned SB_DEPTH   = 4;
  localparam int unsigned MATCH_W    = 3;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CNT_W      = $clog2(SB_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FORCE = 2'd1,
    ST_FENCE = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response bus of the load/store unit.
//   req_valid/req_ready  handshake, req_we 1=store 0=load
//   req_addr/req_wdata   request payload
//   rsp_valid/rsp_rdata  registered load result
interface load_store_unit_if;
  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_we;
  logic [load_store_unit_pkg::ADDR_W-1:0]   req_addr;
  logic [load_store_unit_pkg::DATA_W-1:0]   req_wdata;
  logic                                     rsp_valid;
  logic [load_store_unit_pkg::DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/load_store_unit_store_buffer.sv
// Circular store FIFO with a parallel youngest-match search port.
//   push/push_entry  enqueue at tail      pop         dequeue head
//   head_entry       oldest entry         count       occupancy
//   search_key       low address bits     hit_c/hit_data_c  youngest matching entry
module load_store_unit_store_buffer
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned MATCH = MATCH_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  sb_entry_t                    push_entry,
  input  logic                         pop,
  output sb_entry_t                    head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [MATCH-1:0]             search_key,
  output logic                         hit_c,
  output logic [DATA_W-1:0]            hit_data_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  sb_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CW-1:0]     count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; count decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= push_entry;
  end

  assign head_entry = entries_q[head_q];
  assign count      = count_q;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    hit_c      = 1'b0;
    hit_data_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PTR_W'(i);
      if ((CW'(i) < count_q) && (entries_q[idx].addr[MATCH-1:0] == search_key)) begin
        hit_c      = 1'b1;
        hit_data_c = entries_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: posts stores into a buffer, forwards to loads, and owns the
// single DataMemory port, draining buffered stores whenever no request is taken.
//   clk, rst            clock, synchronous active-high reset
//   req_if (slave)      request handshake and registered load response
//   fence_req/done      drain-all request pulse / completion pulse
//   mem_*               DataMemory port (combinational read data in)
//   sb_count            buffered store count
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH        = SB_DEPTH,
  parameter int unsigned MATCH_BITS   = MATCH_W,
  parameter int unsigned STARVE_LIMIT = STARVE_MAX
) (
  input  logic                        clk,
  input  logic                        rst,
  load_store_unit_if.slave            req_if,
  input  logic                        fence_req,
  output logic                        fence_done,
  output logic [ADDR_W-1:0]           mem_access_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  output logic                        mem_write_en,
  output logic                        mem_read_en,
  input  logic [DATA_W-1:0]           mem_read_data,
  output logic [$clog2(DEPTH+1)-1:0]  sb_count
);

  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  lsu_state_e          state_q;
  logic [STARVE_W-1:0] starve_q;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt_c;
  sb_entry_t           head_entry;
  sb_entry_t           push_entry;
  logic                accept_c;
  logic                load_acc_c;
  logic                store_acc_c;
  logic                drain_c;
  logic                hit_c;
  logic [DATA_W-1:0]   hit_data_c;

  load_store_unit_store_buffer #(
    .DEPTH (DEPTH),
    .MATCH (MATCH_BITS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (store_acc_c),
    .push_entry (push_entry),
    .pop        (drain_c),
    .head_entry (head_entry),
    .count      (count),
    .search_key (req_if.req_addr[MATCH_BITS-1:0]),
    .hit_c      (hit_c),
    .hit_data_c (hit_data_c)
  );

  assign sb_count        = count;
  assign push_entry.addr = req_if.req_addr;
  assign push_entry.data = req_if.req_wdata;

  // Requests only in RUN; a store additionally needs a free slot.
  assign req_if.req_ready = !rst && (state_q == ST_RUN) &&
                            (!req_if.req_we || (count < CW'(DEPTH)));

  assign accept_c    = req_if.req_valid && req_if.req_ready;
  assign load_acc_c  = accept_c && !req_if.req_we;
  assign store_acc_c = accept_c && req_if.req_we;
  // The port is free for a drain whenever no request is taken this cycle.
  assign drain_c     = !rst && !accept_c && (count != '0);
  assign count_nxt_c = count + CW'(store_acc_c) - CW'(drain_c);

  // Single-user DataMemory port: accepted load, else head drain, else idle.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    if (load_acc_c) begin
      mem_read_en     = 1'b1;
      mem_access_addr = req_if.req_addr;
    end else if (drain_c) begin
      mem_write_en    = 1'b1;
      mem_access_addr = head_entry.addr;
      mem_write_data  = head_entry.data;
    end
  end

  // Control FSM, starve counter and load response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      starve_q         <= '0;
      fence_done       <= 1'b0;
      req_if.rsp_valid <= 1'b0;
      req_if.rsp_rdata <= '0;
    end else begin
      fence_done       <= 1'b0;
      req_if.rsp_valid <= load_acc_c;
      if (load_acc_c) begin
        req_if.rsp_rdata <= hit_c ? hit_data_c : mem_read_data;
      end

      if (drain_c || (count == '0)) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end

      case (state_q)
        ST_RUN: begin
          if (fence_req) begin
            // Nothing left after this cycle: complete without entering FENCE.
            if (count_nxt_c == '0) fence_done <= 1'b1;
            else                   state_q    <= ST_FENCE;
          end else if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
            state_q <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (drain_c || (count == '0)) state_q <= ST_RUN;
        end
        ST_FENCE: begin
          if (count_nxt_c == '0) begin
            state_q    <= ST_RUN;
            fence_done <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small DataMemory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic               clk;
  logic               rst;
  logic               fence_req;
  logic               fence_done;
  logic [ADDR_W-1:0]  mem_access_addr;
  logic [DATA_W-1:0]  mem_write_data;
  logic               mem_write_en;
  logic               mem_read_en;
  logic [DATA_W-1:0]  mem_read_data;
  logic [CNT_W-1:0]   sb_count;
  logic [DATA_W-1:0]  dmem [8];

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (bus),
    .fence_req       (fence_req),
    .fence_done      (fence_done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_read_data   (mem_read_data),
    .sb_count        (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory: decodes the low 3 address bits, combinational read.
  assign mem_read_data = dmem[mem_access_addr[2:0]];
  always @(posedge clk) begin
    if (mem_write_en) dmem[mem_access_addr[2:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic drive_load(input logic [15:0] a);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = '0;
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_loads;
    bit  dropped;

    rst       = 1'b1;
    fence_req = 1'b0;
    drive_idle();
    for (int i = 0; i < 8; i++) dmem[i] = '0;
    repeat (3) tick();

    // Reset state
    check("rst_sb_count",  32'(sb_count), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_fence_done", 32'(fence_done), 32'd0);
    check("rst_mem_we",    32'(mem_write_en), 32'd0);
    check("rst_mem_re",    32'(mem_read_en), 32'd0);
    check("rst_mem_addr",  32'(mem_access_addr), 32'd0);
    rst = 1'b0;

    // 1: store then load same address forwards from the buffer
    drive_store(16'd2, 16'h00A5);
    #1 check("t1_store_ready", 32'(bus.req_ready), 32'd1);
    tick();
    drive_load(16'd2);
    #1;
    check("t1_load_re", 32'(mem_read_en), 32'd1);
    check("t1_load_we", 32'(mem_write_en), 32'd0);
    check("t1_load_addr", 32'(mem_access_addr), 32'd2);
    tick();
    drive_idle();
    #1;
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_rdata", 32'(bus.rsp_rdata), 32'h00A5);
    check("t1_count", 32'(sb_count), 32'd1);
    check("t1_drain_we", 32'(mem_write_en), 32'd1);
    check("t1_drain_addr", 32'(mem_access_addr), 32'd2);
    check("t1_drain_data", 32'(mem_write_data), 32'h00A5);
    tick();
    #1;
    check("t1_mem2", 32'(dmem[2]), 32'h00A5);
    check("t1_count_empty", 32'(sb_count), 32'd0);
    check("t1_rsp_valid_off", 32'(bus.rsp_valid), 32'd0);
    check("t1_rsp_held", 32'(bus.rsp_rdata), 32'h00A5);

    // 2: aliasing stores, youngest match wins
    drive_store(16'd1, 16'h1111);
    tick();
    drive_store(16'd9, 16'h2222);
    tick();
    drive_load(16'd1);
    #1 check("t2_count", 32'(sb_count), 32'd2);
    tick();
    drive_idle();
    #1;
    check("t2_rsp_rdata", 32'(bus.rsp_rdata), 32'h2222);
    check("t2_drain0_addr", 32'(mem_access_addr), 32'd1);
    check("t2_drain0_data", 32'(mem_write_data), 32'h1111);
    tick();
    #1;
    check("t2_drain1_addr", 32'(mem_access_addr), 32'd9);
    check("t2_drain1_data", 32'(mem_write_data), 32'h2222);
    tick();
    #1;
    check("t2_mem1", 32'(dmem[1]), 32'h2222);
    check("t2_count_empty", 32'(sb_count), 32'd0);

    // 3: fill buffer, 5th store stalls until a drain, then FIFO-order drains
    for (int i = 0; i < 4; i++) begin
      drive_store(16'(i), 16'h3000 + 16'(i));
      tick();
    end
    drive_store(16'd4, 16'h3004);
    #1;
    check("t3_full_count", 32'(sb_count), 32'd4);
    check("t3_full_ready", 32'(bus.req_ready), 32'd0);
    check("t3_stall_drain_we", 32'(mem_write_en), 32'd1);
    check("t3_stall_drain_addr", 32'(mem_access_addr), 32'd0);
    check("t3_stall_drain_data", 32'(mem_write_data), 32'h3000);
    tick();
    #1 check("t3_ready_after_drain", 32'(bus.req_ready), 32'd1);
    tick();
    drive_idle();
    #1 check("t3_refill_count", 32'(sb_count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      check("t3_fifo_we", 32'(mem_write_en), 32'd1);
      check("t3_fifo_addr", 32'(mem_access_addr), 32'(i));
      check("t3_fifo_data", 32'(mem_write_data), 32'h3000 + 32'(i));
      tick();
    end
    check("t3_count_empty", 32'(sb_count), 32'd0);
    check("t3_mem4", 32'(dmem[4]), 32'h3004);

    // 4: continuous loads starve a buffered store until a forced drain
    drive_store(16'd5, 16'h5555);
    tick();
    drive_load(16'd6);
    n_loads = 0;
    dropped = 1'b0;
    for (int k = 0; k < 20 && !dropped; k++) begin
      #1;
      if (bus.req_ready) begin
        n_loads++;
        tick();
      end else begin
        dropped = 1'b1;
      end
    end
    check("t4_loads_before_force", 32'(n_loads), 32'd9);
    check("t4_force_we", 32'(mem_write_en), 32'd1);
    check("t4_force_re", 32'(mem_read_en), 32'd0);
    check("t4_force_addr", 32'(mem_access_addr), 32'd5);
    check("t4_force_data", 32'(mem_write_data), 32'h5555);
    check("t4_rsp_rdata", 32'(bus.rsp_rdata), 32'h0000);
    tick();
    #1;
    check("t4_run_ready", 32'(bus.req_ready), 32'd1);
    check("t4_count_empty", 32'(sb_count), 32'd0);
    drive_idle();
    tick();

    // 5: fence drains three posted stores, requests blocked meanwhile
    for (int i = 0; i < 3; i++) begin
      drive_store(16'(i), 16'h5A00 + 16'(i));
      tick();
    end
    drive_idle();
    fence_req = 1'b1;
    #1 check("t5_fence_drain0", 32'(mem_access_addr), 32'd0);
    tick();
    fence_req = 1'b0;
    drive_load(16'd0);
    #1;
    check("t5_ready_blocked0", 32'(bus.req_ready), 32'd0);
    check("t5_done_early0", 32'(fence_done), 32'd0);
    check("t5_drain1_addr", 32'(mem_access_addr), 32'd1);
    tick();
    #1;
    check("t5_ready_blocked1", 32'(bus.req_ready), 32'd0);
    check("t5_done_early1", 32'(fence_done), 32'd0);
    check("t5_drain2_addr", 32'(mem_access_addr), 32'd2);
    check("t5_drain2_we", 32'(mem_write_en), 32'd1);
    tick();
    #1;
    check("t5_fence_done", 32'(fence_done), 32'd1);
    check("t5_count_empty", 32'(sb_count), 32'd0);
    check("t5_ready_resumed", 32'(bus.req_ready), 32'd1);
    check("t5_mem0", 32'(dmem[0]), 32'h5A00);
    check("t5_mem1", 32'(dmem[1]), 32'h5A01);
    check("t5_mem2", 32'(dmem[2]), 32'h5A02);
    tick();
    drive_idle();
    #1;
    check("t5_done_pulse", 32'(fence_done), 32'd0);
    check("t5_load_after_fence", 32'(bus.rsp_rdata), 32'h5A00);

    // Fence with an empty buffer completes the following cycle
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    #1 check("t5_empty_fence_done", 32'(fence_done), 32'd1);
    tick();
    #1 check("t5_empty_fence_pulse", 32'(fence_done), 32'd0);

    // 6: reset discards buffered stores
    drive_store(16'd3, 16'h6666);
    tick();
    drive_store(16'd4, 16'h7777);
    tick();
    drive_idle();
    rst = 1'b1;
    #1 check("t6_no_write_in_rst", 32'(mem_write_en), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_count", 32'(sb_count), 32'd0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("t6_fence_done", 32'(fence_done), 32'd0);
    check("t6_mem_addr", 32'(mem_access_addr), 32'd0);
    check("t6_mem_wdata", 32'(mem_write_data), 32'd0);
    check("t6_mem_re", 32'(mem_read_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_write", 32'(mem_write_en), 32'd0);
      tick();
    end
    check("t6_mem3_kept", 32'(dmem[3]), 32'h3003);
    check("t6_mem4_kept", 32'(dmem[4]), 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
